// File: rtl/tetris_pkg.sv
// Shared board geometry, controller state encoding and line-clear score table.
package tetris_pkg;

  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } lc_state_t;

  function automatic logic [3:0] score_for(input logic [4:0] n);
    case (n)
      5'd0:    score_for = 4'd0;
      5'd1:    score_for = 4'd1;
      5'd2:    score_for = 4'd3;
      5'd3:    score_for = 4'd5;
      default: score_for = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/board_shift_down.sv
// Combinational collapse of one row: rows 1..ptr take the row above them,
// row 0 becomes empty, rows below ptr pass through.
module board_shift_down #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int PTR_W   = 5
) (
  input  logic [BOARD_W*BOARD_H-1:0] board,
  input  logic [PTR_W-1:0]           ptr,
  output logic [BOARD_W*BOARD_H-1:0] shifted
);

  generate
    for (genvar gi = 0; gi < BOARD_H; gi++) begin : g_row
      if (gi == 0) begin : g_top
        // The pointer is never negative, so the top row always empties.
        assign shifted[0 +: BOARD_W] = '0;
      end else begin : g_rest
        assign shifted[gi*BOARD_W +: BOARD_W] = (PTR_W'(gi) > ptr)
                                              ? board[gi*BOARD_W +: BOARD_W]
                                              : board[(gi-1)*BOARD_W +: BOARD_W];
      end
    end
  endgenerate

endmodule

// File: rtl/line_clear_ctrl.sv
// Scans a placed-piece board bottom-up, collapsing full rows one at a time,
// then reports the batch size, its score and a saturating lifetime line count.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BOARD_W*BOARD_H-1:0] board_in,
  output logic                       busy,
  output logic                       done,
  output logic                       board_we,
  output logic [BOARD_W*BOARD_H-1:0] board_out,
  output logic [4:0]                 lines_cleared,
  output logic [3:0]                 score_add,
  output logic [15:0]                total_lines
);

  localparam int PTR_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam int CELLS = BOARD_W * BOARD_H;

  lc_state_t state_reg, state_next;

  logic [CELLS-1:0] work_reg;
  logic [CELLS-1:0] shifted;
  logic [PTR_W-1:0] row_ptr_reg;
  logic [4:0]       batch_reg;
  logic [4:0]       lines_reg;
  logic [3:0]       score_reg;
  logic [15:0]      total_reg;
  logic [16:0]      total_sum;
  logic             row_full;
  logic             scan_last;

  assign row_full  = &work_reg[int'(row_ptr_reg)*BOARD_W +: BOARD_W];
  assign scan_last = (state_reg == ST_SCAN) && !row_full && (row_ptr_reg == '0);
  assign total_sum = {1'b0, total_reg} + 17'(batch_reg);

  board_shift_down #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .PTR_W   (PTR_W)
  ) u_shift (
    .board   (work_reg),
    .ptr     (row_ptr_reg),
    .shifted (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SCAN;
      ST_SCAN: begin
        if (row_full)                state_next = ST_SHIFT;
        else if (row_ptr_reg == '0)  state_next = ST_DONE;
      end
      ST_SHIFT: state_next = ST_SCAN;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    board_we = 1'b0;
    if (!rst) begin
      busy     = (state_reg != ST_IDLE);
      done     = (state_reg == ST_DONE);
      board_we = (state_reg == ST_DONE);
    end
  end

  // Batch results are latched on the way into DONE so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg    <= '0;
      row_ptr_reg <= '0;
      batch_reg   <= '0;
      lines_reg   <= '0;
      score_reg   <= '0;
      total_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            work_reg    <= board_in;
            row_ptr_reg <= PTR_W'(BOARD_H - 1);
            batch_reg   <= '0;
          end
        end
        ST_SCAN: begin
          if (row_full)                 batch_reg   <= batch_reg + 5'd1;
          else if (row_ptr_reg != '0)   row_ptr_reg <= row_ptr_reg - 1'b1;
          if (scan_last) begin
            lines_reg <= batch_reg;
            score_reg <= score_for(batch_reg);
            total_reg <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
          end
        end
        ST_SHIFT: work_reg <= shifted;
        default: ;
      endcase
    end
  end

  assign board_out     = work_reg;
  assign lines_cleared = lines_reg;
  assign score_add     = score_reg;
  assign total_lines   = total_reg;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized and directed bench for line_clear_ctrl against a row-compaction model.
module tb_line_clear_ctrl;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] board_in;
  logic         busy;
  logic         done;
  logic         board_we;
  logic [N-1:0] board_out;
  logic [4:0]   lines_cleared;
  logic [3:0]   score_add;
  logic [15:0]  total_lines;

  int n_checks = 0;
  int n_fail   = 0;
  int total_model = 0;

  always #5 clk = ~clk;

  line_clear_ctrl #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_we      (board_we),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .score_add     (score_add),
    .total_lines   (total_lines)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Surviving rows keep their order and settle at the bottom; full rows vanish.
  function automatic void model(input logic [N-1:0] b, output logic [N-1:0] res, output int k);
    logic [W-1:0] rows_q[$];
    res = '0;
    k = 0;
    for (int r = H - 1; r >= 0; r--) begin
      if (b[r*W +: W] == {W{1'b1}}) k++;
      else rows_q.push_back(b[r*W +: W]);
    end
    for (int j = 0; j < rows_q.size(); j++) res[(H-1-j)*W +: W] = rows_q[j];
  endfunction

  function automatic int score_model(input int k);
    if (k == 0)      return 0;
    else if (k == 1) return 1;
    else if (k == 2) return 3;
    else if (k == 3) return 5;
    else             return 8;
  endfunction

  task automatic run_batch(input string name, input logic [N-1:0] b, input int repulse);
    logic [N-1:0] exp_b;
    int k, lat, first, dones, bad_we, rp;
    model(b, exp_b, k);
    lat = 21 + 2 * k;
    rp  = (repulse < 0) ? lat : repulse;
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = -1; dones = 0; bad_we = 0;
    for (int i = 1; i <= lat + 3; i++) begin
      if (i > 1) @(negedge clk);
      start = (i == rp);
      if (i == 1) chk("busy_after_start", 256'(busy), 256'(1));
      if (done) begin
        dones++;
        if (first < 0) first = i;
      end
      if (board_we !== done) bad_we++;
    end
    start = 1'b0;
    total_model = (total_model + k > 65535) ? 65535 : total_model + k;
    chk("done_latency",  256'(first), 256'(lat));
    chk("done_count",    256'(dones), 256'(1));
    chk("we_with_done",  256'(bad_we), 256'(0));
    chk("idle_after",    256'(busy), 256'(0));
    chk("lines_cleared", 256'(lines_cleared), 256'(k));
    chk("score_add",     256'(score_add), 256'(score_model(k)));
    chk("total_lines",   256'(total_lines), 256'(total_model));
    chk("board_out",     256'(board_out), 256'(exp_b));
    $display("batch %s k=%0d lat=%0d lines=%0d score=%0d total=%0d",
             name, k, first, lines_cleared, score_add, total_lines);
  endtask

  initial begin
    logic [N-1:0] b;
    int dones;

    rst = 1'b1; start = 1'b1; board_in = '1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  256'(busy), 256'(0));
    chk("rst_done",  256'(done), 256'(0));
    chk("rst_we",    256'(board_we), 256'(0));
    chk("rst_lines", 256'(lines_cleared), 256'(0));
    chk("rst_score", 256'(score_add), 256'(0));
    chk("rst_total", 256'(total_lines), 256'(0));
    chk("rst_board", 256'(board_out), 256'(0));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 256'(busy), 256'(0));

    b = '0;
    run_batch("empty", b, 0);

    b = '0; b[19*W +: W] = '1; b[18*W +: W] = 10'b0000000001;
    run_batch("one_line", b, 0);

    b = '0; b[15*W +: W] = 10'h155;
    for (int r = 16; r < 20; r++) b[r*W +: W] = '1;
    run_batch("tetris", b, 5);

    b = '0; b[19*W +: W] = '1; b[17*W +: W] = '1; b[18*W +: W] = 10'h0F0;
    run_batch("split_two", b, -1);

    for (int t = 0; t < 24; t++) begin
      for (int r = 0; r < H; r++)
        b[r*W +: W] = ($urandom_range(0, 2) == 0) ? {W{1'b1}} : W'($urandom());
      run_batch($sformatf("rand%0d", t), b, (t % 3 == 0) ? int'($urandom_range(2, 20)) : 0);
    end

    // Reset during SCAN abandons the batch and clears the lifetime count.
    @(negedge clk);
    board_in = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_done", 256'(done), 256'(0));
    @(negedge clk);
    chk("midrst_total", 256'(total_lines), 256'(0));
    chk("midrst_board", 256'(board_out), 256'(0));
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || board_we || busy) dones++;
    end
    chk("midrst_no_done", 256'(dones), 256'(0));
    total_model = 0;
    $display("batch midrst total=%0d", total_lines);

    // Preload the lifetime count near its ceiling, then keep clearing 4 lines.
    force dut.total_reg = 16'hFFF0;
    @(negedge clk);
    release dut.total_reg;
    total_model = 16'hFFF0;
    b = '0; b[15*W +: W] = 10'h155;
    for (int r = 16; r < 20; r++) b[r*W +: W] = '1;
    for (int t = 0; t < 6; t++) run_batch($sformatf("sat%0d", t), b, 0);
    chk("sat_hold", 256'(total_lines), 256'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
